// File: rtl/instrument_axil_regfile_if.sv
// AXI4-Lite bundle between the PS interconnect (master) and the instrument register file (slave).
interface instrument_axil_regfile_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/instrument_axil_regfile.sv
// AXI4-Lite register file: NUM_REGS control words with byte-lane writes, RO_MASK slots read live status.
// Write (AW/W in any order) and read channels run as independent two-state FSMs.
module instrument_axil_regfile #(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    instrument_axil_regfile_if.slave               s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;
    localparam int NB = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic [DW-1:0] regs [NUM_REGS];

    logic          aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]    b_resp_q;
    logic          aw_seen, w_seen;
    logic [IW-1:0] aw_idx_q;
    logic [DW-1:0] w_data_q;
    logic [NB-1:0] w_strb_q;

    logic          ar_ready_q, r_valid_q;
    logic [DW-1:0] r_data_q;
    logic [1:0]    r_resp_q;

    logic                aw_hs, w_hs, ar_hs, wr_commit, wr_ok, wr_ro, rd_hit;
    logic [IW-1:0]       wr_idx, rd_idx;
    logic [DW-1:0]       wr_data, rd_word;
    logic [NB-1:0]       wr_strb;
    logic [NUM_REGS-1:0] wr_hit;

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Merge whichever half arrived earlier with the half arriving this cycle to form the commit.
    always_comb begin
        aw_hs     = s_axi.S_AXI_AWVALID & aw_ready_q;
        w_hs      = s_axi.S_AXI_WVALID & w_ready_q;
        wr_idx    = aw_hs ? s_axi.S_AXI_AWADDR[AW-1:2] : aw_idx_q;
        wr_data   = w_hs ? s_axi.S_AXI_WDATA : w_data_q;
        wr_strb   = w_hs ? s_axi.S_AXI_WSTRB : w_strb_q;
        wr_commit = (wr_state == W_IDLE) & (aw_seen | aw_hs) & (w_seen | w_hs);
        wr_hit    = '0;
        wr_ro     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IW'(i)) begin
                wr_hit[i] = 1'b1;
                wr_ro     = RO_MASK[i];
            end
        end
        wr_ok = (|wr_hit) & ~wr_ro;
    end

    always_comb begin
        ar_hs   = s_axi.S_AXI_ARVALID & ar_ready_q;
        rd_idx  = s_axi.S_AXI_ARADDR[AW-1:2];
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_hit  = 1'b1;
                rd_word = RO_MASK[i] ? status_in[i*DW +: DW] : regs[i];
            end
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        rd_state_next = rd_state;
        case (wr_state)
            W_IDLE:  if (wr_commit) wr_state_next = W_RESP;
            W_RESP:  if (b_valid_q & s_axi.S_AXI_BREADY) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
            R_DATA:  if (r_valid_q & s_axi.S_AXI_RREADY) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    // Readies are registered: each drops on its own handshake and rises again only once back in idle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) aw_idx_q <= s_axi.S_AXI_AWADDR[AW-1:2];
                    if (w_hs) begin
                        w_data_q <= s_axi.S_AXI_WDATA;
                        w_strb_q <= s_axi.S_AXI_WSTRB;
                    end
                    if (wr_commit) begin
                        aw_seen    <= 1'b0;
                        w_seen     <= 1'b0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        aw_seen    <= aw_seen | aw_hs;
                        w_seen     <= w_seen | w_hs;
                        aw_ready_q <= ~(aw_seen | aw_hs);
                        w_ready_q  <= ~(w_seen | w_hs);
                    end
                end
                W_RESP: begin
                    if (b_valid_q & s_axi.S_AXI_BREADY) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
                default: b_valid_q <= 1'b0;
            endcase
        end
    end

    // RO slots are never written, so their ctrl_out words stay zero.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= (wr_commit & wr_ok) ? wr_hit : '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_commit & wr_ok & wr_hit[i] & wr_strb[b])
                        regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_data_q   <= rd_word;
                        r_resp_q   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_valid_q & s_axi.S_AXI_RREADY) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                    end
                end
                default: r_valid_q <= 1'b0;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = aw_ready_q;
    assign s_axi.S_AXI_WREADY  = w_ready_q;
    assign s_axi.S_AXI_BVALID  = b_valid_q;
    assign s_axi.S_AXI_BRESP   = b_resp_q;
    assign s_axi.S_AXI_ARREADY = ar_ready_q;
    assign s_axi.S_AXI_RVALID  = r_valid_q;
    assign s_axi.S_AXI_RDATA   = r_data_q;
    assign s_axi.S_AXI_RRESP   = r_resp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_out[g*DW +: DW] = regs[g];
    end
endmodule

// File: tb/tb_instrument_axil_regfile.sv
// Directed bench for instrument_axil_regfile (NUM_REGS=8, reg 7 read-only status).
module tb_instrument_axil_regfile;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] ctrl_out;
    logic [255:0] status_in;
    logic [7:0]   wr_pulse;
    int total = 0;
    int bad = 0;

    instrument_axil_regfile_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    instrument_axil_regfile #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_REGS(8),
        .RO_MASK(8'h80)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(bus),
        .ctrl_out(ctrl_out),
        .status_in(status_in),
        .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    // Drive AW and W together; report BRESP plus wr_pulse just after commit and one cycle later.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] p1, output logic [7:0] p2);
        bit aw_ok = 0;
        bit w_ok = 0;
        int n = 0;
        @(negedge clk);
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
        while (!(aw_ok && w_ok) && n < 50) begin
            bit aw_hit = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            bit w_hit = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); @(negedge clk);
            if (aw_hit) begin aw_ok = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_hit) begin w_ok = 1; bus.S_AXI_WVALID = 1'b0; end
            n++;
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        p1 = wr_pulse;
        bus.S_AXI_BREADY = 1'b1;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
        resp = bus.S_AXI_BVALID ? bus.S_AXI_BRESP : 2'bxx;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        p2 = wr_pulse;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        int n = 0;
        @(negedge clk);
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        lat = 0;
        while (!bus.S_AXI_RVALID && lat < 50) begin @(negedge clk); lat++; end
        data = bus.S_AXI_RVALID ? bus.S_AXI_RDATA : 32'hxxxxxxxx;
        resp = bus.S_AXI_RVALID ? bus.S_AXI_RRESP : 2'bxx;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_handshake: got %b want 00000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
        total++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, wr_pulse} !== 44'h0) begin
            bad++; $display("[TB] FAIL reset_resp_data: bresp=%b rresp=%b rdata=%h pulse=%h want zeros",
                bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, wr_pulse);
        end
        total++;
        if (ctrl_out !== 256'h0) begin bad++; $display("[TB] FAIL reset_ctrl: got %h want 0", ctrl_out); end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            bad++; $display("[TB] FAIL ready_after_reset: got %b want 111",
                {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] data; int lat;
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i*4), 32'(i+1), 4'hF, resp, p1, p2);
            total++;
            if (resp !== 2'b00) begin bad++; $display("[TB] FAIL basic_bresp[%0d]: got %b want 00", i, resp); end
            total++;
            if (p1 !== 8'(1 << i) || p2 !== 8'h00) begin
                bad++; $display("[TB] FAIL basic_pulse[%0d]: got %h/%h want %h/00", i, p1, p2, 8'(1 << i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i*4), data, resp, lat);
            total++;
            if (data !== 32'(i+1) || resp !== 2'b00) begin
                bad++; $display("[TB] FAIL basic_read[%0d]: got %h/%b want %h/00", i, data, resp, 32'(i+1));
            end
            total++;
            if (lat !== 0) begin bad++; $display("[TB] FAIL read_latency[%0d]: got %0d want 0", i, lat); end
        end
        total++;
        if (ctrl_out[127:0] !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
            bad++; $display("[TB] FAIL basic_ctrl: got %h want 00000004000000030000000200000001", ctrl_out[127:0]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] data; logic [1:0] resp; int lat;
        @(negedge clk);
        bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        total++;
        if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 3'b010) begin
            bad++; $display("[TB] FAIL w_first_state: got %b want 010",
                {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (bus.S_AXI_BVALID !== 1'b0) begin bad++; $display("[TB] FAIL w_first_early_b[%0d]: got 1 want 0", k); end
        end
        bus.S_AXI_AWADDR = 6'h04; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        total++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 5'b10000 || wr_pulse !== 8'h02) begin
            bad++; $display("[TB] FAIL w_first_commit: b/resp/rdy=%b pulse=%h want 10000 02",
                {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, wr_pulse);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        total++;
        if (bus.S_AXI_BVALID !== 1'b0 || wr_pulse !== 8'h00) begin
            bad++; $display("[TB] FAIL w_first_done: bvalid=%b pulse=%h want 0 00", bus.S_AXI_BVALID, wr_pulse);
        end
        axi_read(6'h04, data, resp, lat);
        total++;
        if (data !== 32'hDEADBEEF || resp !== 2'b00) begin
            bad++; $display("[TB] FAIL w_first_read: got %h/%b want deadbeef/00", data, resp);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] data; int lat;
        axi_write(6'h00, 32'hFFFFFFFF, 4'hF, resp, p1, p2);
        axi_write(6'h00, 32'h12345678, 4'b0101, resp, p1, p2);
        total++;
        if (resp !== 2'b00 || p1 !== 8'h01 || p2 !== 8'h00) begin
            bad++; $display("[TB] FAIL strobe_write: resp=%b pulse=%h/%h want 00 01/00", resp, p1, p2);
        end
        axi_read(6'h00, data, resp, lat);
        total++;
        if (data !== 32'hFF34FF78) begin bad++; $display("[TB] FAIL strobe_read: got %h want ff34ff78", data); end
    endtask

    task automatic test_zero_strobe_unaligned();
        logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] data; int lat;
        axi_write(6'h0A, 32'hFFFFFFFF, 4'h0, resp, p1, p2);
        total++;
        if (resp !== 2'b00 || p1 !== 8'h04) begin
            bad++; $display("[TB] FAIL zero_strobe: resp=%b pulse=%h want 00 04", resp, p1);
        end
        axi_read(6'h09, data, resp, lat);
        total++;
        if (data !== 32'h00000003) begin bad++; $display("[TB] FAIL zero_strobe_read: got %h want 00000003", data); end
        axi_write(6'h0B, 32'h000000A5, 4'b0001, resp, p1, p2);
        axi_read(6'h08, data, resp, lat);
        total++;
        if (data !== 32'h000000A5) begin bad++; $display("[TB] FAIL unaligned_read: got %h want 000000a5", data); end
    endtask

    task automatic test_read_only();
        logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] data; int lat;
        axi_read(6'h1C, data, resp, lat);
        total++;
        if (data !== 32'hCAFE0001 || resp !== 2'b00) begin
            bad++; $display("[TB] FAIL ro_read: got %h/%b want cafe0001/00", data, resp);
        end
        axi_write(6'h1C, 32'h11111111, 4'hF, resp, p1, p2);
        total++;
        if (resp !== 2'b10 || p1 !== 8'h00) begin
            bad++; $display("[TB] FAIL ro_write: resp=%b pulse=%h want 10 00", resp, p1);
        end
        status_in[255:224] = 32'h0BADF00D;
        axi_read(6'h1D, data, resp, lat);
        total++;
        if (data !== 32'h0BADF00D) begin bad++; $display("[TB] FAIL ro_live: got %h want 0badf00d", data); end
        total++;
        if (ctrl_out[255:224] !== 32'h0) begin bad++; $display("[TB] FAIL ro_ctrl: got %h want 0", ctrl_out[255:224]); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] data; int lat;
        axi_read(6'h20, data, resp, lat);
        total++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            bad++; $display("[TB] FAIL oor_read: got %h/%b want 00000000/10", data, resp);
        end
        axi_write(6'h20, 32'hAAAAAAAA, 4'hF, resp, p1, p2);
        total++;
        if (resp !== 2'b10 || p1 !== 8'h00) begin
            bad++; $display("[TB] FAIL oor_write20: resp=%b pulse=%h want 10 00", resp, p1);
        end
        axi_write(6'h3C, 32'h55555555, 4'hF, resp, p1, p2);
        total++;
        if (resp !== 2'b10) begin bad++; $display("[TB] FAIL oor_write3c: resp=%b want 10", resp); end
        total++;
        if (ctrl_out !== {32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'hA5, 32'hDEADBEEF, 32'hFF34FF78}) begin
            bad++; $display("[TB] FAIL oor_ctrl: got %h", ctrl_out);
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] data; logic [1:0] resp; int lat;
        @(negedge clk);
        bus.S_AXI_ARADDR = 6'h0C; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h99; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        total++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h4 || bus.S_AXI_BVALID !== 1'b1) begin
            bad++; $display("[TB] FAIL same_edge: rvalid=%b rdata=%h bvalid=%b want 1 00000004 1",
                bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BVALID);
        end
        bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        axi_read(6'h0C, data, resp, lat);
        total++;
        if (data !== 32'h99) begin bad++; $display("[TB] FAIL same_edge_after: got %h want 00000099", data); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [7:0] p1, p2; logic [31:0] data; int lat;
        @(negedge clk);
        bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 6'h00; bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
                bad++; $display("[TB] FAIL b_hold[%0d]: bvalid=%b bresp=%b want 1 00", k, bus.S_AXI_BVALID, bus.S_AXI_BRESP);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 4'b0 || ctrl_out !== 256'h0) begin
            bad++; $display("[TB] FAIL mid_reset: b/r/awr/arr=%b ctrl=%h want 0000 0",
                {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, ctrl_out);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID} !== 4'b1110) begin
            bad++; $display("[TB] FAIL post_reset_ready: got %b want 1110",
                {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID});
        end
        axi_write(6'h00, 32'h77, 4'hF, resp, p1, p2);
        total++;
        if (resp !== 2'b00 || p1 !== 8'h01) begin
            bad++; $display("[TB] FAIL post_reset_write: resp=%b pulse=%h want 00 01", resp, p1);
        end
        axi_read(6'h00, data, resp, lat);
        total++;
        if (data !== 32'h77) begin bad++; $display("[TB] FAIL post_reset_read0: got %h want 00000077", data); end
        axi_read(6'h08, data, resp, lat);
        total++;
        if (data !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_read2: got %h want 0", data); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        status_in = '0;
        status_in[31:0] = 32'hBAD00000;
        status_in[255:224] = 32'hCAFE0001;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_zero_strobe_unaligned();
        test_read_only();
        test_out_of_range();
        test_same_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
